// File: rtl/cdf_load_pkg.sv
// cdf_pkg: shared widths, latency bound and FSM encoding for CDF load stages.
// Optional saturation is enabled with CDF_LOAD_SATURATE_EN.
package cdf_pkg;

    localparam int CDF_ADDR_W = 16;
    localparam int CDF_DATA_W = 20;
    localparam int CDF_BUS_W  = 128;
    localparam int CDF_LANE_W = 32;

    localparam int CDF_MAX_READ_LATENCY = 7;
    localparam int CDF_WAIT_W = $clog2(CDF_MAX_READ_LATENCY + 1);

    typedef logic [2:0] cdf_state_t;

    localparam cdf_state_t S_IDLE   = 3'd0;
    localparam cdf_state_t S_ISSUE  = 3'd1;
    localparam cdf_state_t S_WAIT   = 3'd2;
    localparam cdf_state_t S_UNPACK = 3'd3;
    localparam cdf_state_t S_FINISH = 3'd4;

endpackage

// File: rtl/cdf_load_if.sv
// cdf_load_if: launch, memory read port and bin stream of the CDF loader.
// OverflowOut exists only when CDF_LOAD_SATURATE_EN is defined.
interface cdf_load_if;
    import cdf_pkg::*;

    logic                  StartIn;
    logic [CDF_ADDR_W-1:0] BaseAddressIn;
    logic [CDF_ADDR_W-1:0] WordCountIn;
    logic [CDF_BUS_W-1:0]  ReadBus;
    logic [CDF_ADDR_W-1:0] ReadAddress;
    logic                  ReadEnable;
    logic [CDF_DATA_W-1:0] ResultOut;
    logic [CDF_ADDR_W-1:0] BinIndexOut;
    logic                  StartOut;
    logic                  Busy;
    logic                  Done;
`ifdef CDF_LOAD_SATURATE_EN
    logic                  OverflowOut;
`endif

    modport master (
        input  StartIn, BaseAddressIn, WordCountIn, ReadBus,
        output ReadAddress, ReadEnable, ResultOut, BinIndexOut,
        output StartOut, Busy, Done
`ifdef CDF_LOAD_SATURATE_EN
        , output OverflowOut
`endif
    );

    modport slave (
        output StartIn, BaseAddressIn, WordCountIn, ReadBus,
        input  ReadAddress, ReadEnable, ResultOut, BinIndexOut,
        input  StartOut, Busy, Done
`ifdef CDF_LOAD_SATURATE_EN
        , input OverflowOut
`endif
    );

endinterface

// File: rtl/cdf_lane_unpack.sv
// cdf_lane_unpack: picks one 32-bit lane of a 128-bit word and narrows it.
// With CDF_LOAD_SATURATE_EN, out-of-range lanes clamp to all ones.
module cdf_lane_unpack
    import cdf_pkg::*;
(
    input  logic [CDF_BUS_W-1:0]  word,
    input  logic [1:0]            lane,
    output logic [CDF_DATA_W-1:0] value
`ifdef CDF_LOAD_SATURATE_EN
    ,
    output logic                  sat
`endif
);

    logic [CDF_LANE_W-1:0] lane_w;

    // select the addressed lane, lane 0 in the low bits
    always_comb begin
        lane_w = word[lane*CDF_LANE_W +: CDF_LANE_W];
    end

`ifdef CDF_LOAD_SATURATE_EN
    assign sat   = |lane_w[CDF_LANE_W-1:CDF_DATA_W];
    assign value = sat ? '1 : lane_w[CDF_DATA_W-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^lane_w[CDF_LANE_W-1:CDF_DATA_W];
    assign value     = lane_w[CDF_DATA_W-1:0];
`endif

endmodule

// File: rtl/cdf_load.sv
// cdf_load: bursts packed histogram words from memory, streams one bin per cycle.
// CDF_LOAD_SATURATE_EN adds lane clamping and the sticky OverflowOut flag.
module cdf_load
    import cdf_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int LANES        = 4
) (
    input logic        clock,
    input logic        reset_n,
    cdf_load_if.master bus
);

    localparam logic [1:0] LANE_LAST = 2'(LANES - 1);
    localparam logic [CDF_WAIT_W-1:0] WAIT_LAST =
        CDF_WAIT_W'(READ_LATENCY - 1);

    cdf_state_t            state;
    logic [CDF_ADDR_W-1:0] addr;
    logic [CDF_ADDR_W-1:0] left;
    logic [CDF_ADDR_W-3:0] word_idx;
    logic [1:0]            lane;
    logic [CDF_WAIT_W-1:0] wait_cnt;
    logic [CDF_BUS_W-1:0]  word_reg;

    logic                  rd_en;
    logic [CDF_ADDR_W-1:0] rd_addr;
    logic [CDF_DATA_W-1:0] res;
    logic [CDF_ADDR_W-1:0] bin;
    logic                  vld;
    logic                  busy;
    logic                  done_r;

    logic [CDF_BUS_W-1:0]  src_word;
    logic [1:0]            src_lane;
    logic [CDF_DATA_W-1:0] lane_val;
`ifdef CDF_LOAD_SATURATE_EN
    logic                  lane_sat;
    logic                  ovf;
`endif

    // lane 0 comes straight off the bus, later lanes from the held word
    always_comb begin
        src_word = word_reg;
        src_lane = lane + 2'd1;
        if (state == S_WAIT) begin
            src_word = bus.ReadBus;
            src_lane = 2'd0;
        end
    end

    cdf_lane_unpack u_unpack (
        .word  (src_word),
        .lane  (src_lane),
        .value (lane_val)
`ifdef CDF_LOAD_SATURATE_EN
        ,
        .sat   (lane_sat)
`endif
    );

    // burst sequencer with registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            addr     <= '0;
            left     <= '0;
            word_idx <= '0;
            lane     <= '0;
            wait_cnt <= '0;
            word_reg <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            res      <= '0;
            bin      <= '0;
            vld      <= 1'b0;
            busy     <= 1'b0;
            done_r   <= 1'b0;
`ifdef CDF_LOAD_SATURATE_EN
            ovf      <= 1'b0;
`endif
        end else begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            res     <= '0;
            bin     <= '0;
            vld     <= 1'b0;
            done_r  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.StartIn) begin
                        addr     <= bus.BaseAddressIn;
                        left     <= bus.WordCountIn;
                        word_idx <= '0;
                        busy     <= 1'b1;
`ifdef CDF_LOAD_SATURATE_EN
                        ovf      <= 1'b0;
`endif
                        if (bus.WordCountIn != '0) begin
                            state   <= S_ISSUE;
                            rd_en   <= 1'b1;
                            rd_addr <= bus.BaseAddressIn;
                        end else begin
                            state  <= S_FINISH;
                            done_r <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        word_reg <= bus.ReadBus;
                        lane     <= '0;
                        state    <= S_UNPACK;
                        vld      <= 1'b1;
                        res      <= lane_val;
                        bin      <= {word_idx, src_lane};
`ifdef CDF_LOAD_SATURATE_EN
                        ovf      <= ovf | lane_sat;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_UNPACK: begin
                    if (lane == LANE_LAST) begin
                        lane     <= '0;
                        word_idx <= word_idx + 1'b1;
                        left     <= left - 1'b1;
                        if (left > 16'd1) begin
                            addr    <= addr + 1'b1;
                            state   <= S_ISSUE;
                            rd_en   <= 1'b1;
                            rd_addr <= addr + 1'b1;
                        end else begin
                            state  <= S_FINISH;
                            done_r <= 1'b1;
                        end
                    end else begin
                        lane <= src_lane;
                        vld  <= 1'b1;
                        res  <= lane_val;
                        bin  <= {word_idx, src_lane};
`ifdef CDF_LOAD_SATURATE_EN
                        ovf  <= ovf | lane_sat;
`endif
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ReadEnable  = rd_en;
    assign bus.ReadAddress = rd_addr;
    assign bus.ResultOut   = res;
    assign bus.BinIndexOut = bin;
    assign bus.StartOut    = vld;
    assign bus.Busy        = busy;
    assign bus.Done        = done_r;
`ifdef CDF_LOAD_SATURATE_EN
    assign bus.OverflowOut = ovf;
`endif

endmodule

// File: tb/tb_cdf_load.sv
// tb_cdf_load: directed and random bursts against a timing/data model
// of the CDF loader, with a latency-accurate memory stub.
module tb_cdf_load;

    localparam int RL   = 2;
    localparam int SPAN = RL + 5;

    typedef struct {
        int          c;
        logic [15:0] a;
        logic [19:0] r;
        logic [15:0] b;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   viol   = 0;
    int   busy_n = 0;

    ev_t  rd_q[$];
    ev_t  out_q[$];
    int   done_q[$];

    logic [127:0] mem [logic [15:0]];
    logic [127:0] pipe [RL];

    cdf_load_if bus();

    cdf_load #(.READ_LATENCY(RL), .LANES(4)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // memory stub: data appears RL cycles after the strobe cycle, junk otherwise
    always @(posedge clk) begin
        if (bus.ReadEnable) pipe[0] <= mem[bus.ReadAddress];
        else pipe[0] <= {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.ReadBus = pipe[RL-1];

    // event recorder, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.ReadEnable)
            rd_q.push_back('{cyc, bus.ReadAddress, 20'd0, 16'd0});
        else if (bus.ReadAddress != 16'd0)
            viol++;
        if (bus.StartOut)
            out_q.push_back('{cyc, 16'd0, bus.ResultOut, bus.BinIndexOut});
        else if (bus.ResultOut != 20'd0 || bus.BinIndexOut != 16'd0)
            viol++;
        if (bus.Done) done_q.push_back(cyc);
        if (bus.Busy) busy_n++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check(tag, {bus.ReadEnable, bus.ReadAddress, bus.ResultOut,
                    bus.BinIndexOut, bus.StartOut, bus.Busy, bus.Done}, 64'd0);
    endtask

    function automatic logic [19:0] exp_val(input logic [31:0] l);
`ifdef CDF_LOAD_SATURATE_EN
        return (l[31:20] != 12'd0) ? 20'hFFFFF : l[19:0];
`else
        return l[19:0];
`endif
    endfunction

    task automatic fill(input logic [15:0] base, input int n);
        for (int w = 0; w < n; w++)
            mem[base + 16'(w)] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_burst(input string tag, input logic [15:0] base,
                             input int n, input bit mid, input bit at_done);
        int c, tdone, r0, o0, d0, v0, b0, idx;
        ev_t e;
        logic [127:0] wv;
        logic [15:0] a;
        @(negedge clk);
        #1;
        r0 = rd_q.size();
        o0 = out_q.size();
        d0 = done_q.size();
        v0 = viol;
        b0 = busy_n;
        bus.StartIn       = 1'b1;
        bus.BaseAddressIn = base;
        bus.WordCountIn   = 16'(n);
        c = cyc;
        @(negedge clk);
        bus.StartIn       = 1'b0;
        bus.BaseAddressIn = 16'($urandom);
        bus.WordCountIn   = 16'($urandom);
        tdone = c + 1 + n * SPAN;
        while (cyc < tdone + 4) begin
            if ((mid && cyc == c + 4) || (at_done && cyc == tdone)) begin
                bus.StartIn       = 1'b1;
                bus.BaseAddressIn = 16'($urandom);
                bus.WordCountIn   = 16'($urandom_range(1, 4));
            end else begin
                bus.StartIn = 1'b0;
            end
            @(negedge clk);
        end
        bus.StartIn = 1'b0;
        #1;
        check({tag, ".reads"}, rd_q.size() - r0, n);
        check({tag, ".bins"}, out_q.size() - o0, 4 * n);
        for (int w = 0; w < n; w++) begin
            a  = base + 16'(w);
            wv = mem[a];
            if (r0 + w < rd_q.size()) begin
                e = rd_q[r0 + w];
                check($sformatf("%s.rd%0d.cyc", tag, w), e.c, c + 1 + w * SPAN);
                check($sformatf("%s.rd%0d.addr", tag, w), e.a, a);
            end
            for (int k = 0; k < 4; k++) begin
                idx = o0 + w * 4 + k;
                if (idx < out_q.size()) begin
                    e = out_q[idx];
                    check($sformatf("%s.b%0d.cyc", tag, w * 4 + k), e.c,
                          c + 2 + RL + w * SPAN + k);
                    check($sformatf("%s.b%0d.val", tag, w * 4 + k), e.r,
                          exp_val(wv[32*k +: 32]));
                    check($sformatf("%s.b%0d.idx", tag, w * 4 + k), e.b,
                          16'(w * 4 + k));
                end
            end
        end
        check({tag, ".dones"}, done_q.size() - d0, 1);
        if (done_q.size() > d0)
            check({tag, ".done_cyc"}, done_q[d0], tdone);
        if (n > 0)
            check({tag, ".busy_cycles"}, busy_n - b0, tdone - c);
        check({tag, ".idle_zero"}, viol - v0, 0);
    endtask

    initial begin
        int c, r0, o0, d0;
        int n;
        logic [15:0] base;
        bus.StartIn       = 1'b0;
        bus.BaseAddressIn = 16'd0;
        bus.WordCountIn   = 16'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset.hold");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_zero("reset.release");

        mem[16'h0010] = {32'd4, 32'd3, 32'd2, 32'd1};
        run_burst("basic", 16'h0010, 1, 1'b0, 1'b0);

        fill(16'h0100, 3);
        run_burst("multi", 16'h0100, 3, 1'b0, 1'b1);

        run_burst("zero", 16'h1234, 0, 1'b0, 1'b0);

        fill(16'hFFFF, 2);
        run_burst("wrap", 16'hFFFF, 2, 1'b1, 1'b0);

        fill(16'h0200, 3);
        @(negedge clk);
        #1;
        r0 = rd_q.size();
        o0 = out_q.size();
        d0 = done_q.size();
        bus.StartIn       = 1'b1;
        bus.BaseAddressIn = 16'h0200;
        bus.WordCountIn   = 16'd3;
        c = cyc;
        @(negedge clk);
        bus.StartIn = 1'b0;
        while (cyc < c + 12) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst.async");
`ifdef CDF_LOAD_SATURATE_EN
        check("rst.ovf", bus.OverflowOut, 1'b0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_zero("rst.after");
        repeat (10) @(negedge clk);
        #1;
        check("rst.no_done", done_q.size() - d0, 0);
        check("rst.reads", rd_q.size() - r0, 2);
        check("rst.bins", out_q.size() - o0, 6);
        fill(16'h0300, 2);
        run_burst("rst.rerun", 16'h0300, 2, 1'b0, 1'b0);

        mem[16'h0400] = {32'h0000_0003, 32'h000F_FFFF,
                         32'h0000_0001, 32'h0010_0005};
        run_burst("sat", 16'h0400, 1, 1'b0, 1'b0);
`ifdef CDF_LOAD_SATURATE_EN
        check("sat.ovf_set", bus.OverflowOut, 1'b1);
`endif
        mem[16'h0500] = {32'd40, 32'd30, 32'd20, 32'd10};
        run_burst("clean", 16'h0500, 1, 1'b0, 1'b0);
`ifdef CDF_LOAD_SATURATE_EN
        check("clean.ovf_clr", bus.OverflowOut, 1'b0);
`endif

        for (int i = 0; i < 6; i++) begin
            base = 16'($urandom);
            n    = $urandom_range(0, 4);
            fill(base, n);
            run_burst($sformatf("rand%0d", i), base, n,
                      (n > 0) && ($urandom_range(0, 1) == 1),
                      $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
